// File: rtl/score_bcd_counter.sv
// Packed-BCD game score counter: edge-detected point events, wrap or saturate at all-9s.
// Optional high-score tracking is built only when SCORE_HISCORE_EN is defined.
module score_bcd_counter #(
  parameter int NUM_DIGITS = 3,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    point,
  input  logic                    clear,
  input  logic                    game_over,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] hiscore_bcd,
  output logic                    new_record
);

  localparam int W = 4 * NUM_DIGITS;

  logic          point_q;
  logic          inc;
  logic [W-1:0]  score_reg;
  logic [W-1:0]  score_next;
  logic [W-1:0]  score_plus_one;
  logic          overflow_reg;
  logic          overflow_next;
  logic          at_max;
  logic [NUM_DIGITS:0] carry;

  assign inc = point & ~point_q;

  // The +1 value is formed every cycle; carry out of the top digit means all digits are 9.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic       is_nine;

      assign digit   = score_reg[4*gi +: 4];
      assign is_nine = (digit == 4'd9);
      assign carry[gi+1] = carry[gi] & is_nine;

      always_comb begin
        score_plus_one[4*gi +: 4] = digit;
        if (carry[gi]) begin
          score_plus_one[4*gi +: 4] = is_nine ? 4'd0 : digit + 4'd1;
        end
      end
    end
  endgenerate

  assign at_max = carry[NUM_DIGITS];

  always_comb begin
    score_next    = score_reg;
    overflow_next = 1'b0;
    if (clear) begin
      score_next    = '0;
      overflow_next = 1'b0;
    end else if (inc) begin
      overflow_next = at_max;
      if (!(at_max && SATURATE)) begin
        score_next = score_plus_one;
      end
    end
  end

  // point_q resets high so a point held through reset is ignored until seen low.
  always_ff @(posedge clk) begin
    if (reset) begin
      point_q      <= 1'b1;
      score_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      point_q      <= point;
      score_reg    <= score_next;
      overflow_reg <= overflow_next;
    end
  end

  assign score_bcd = score_reg;
  assign overflow  = overflow_reg;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] hiscore_reg;
  logic         new_record_reg;
  logic         beats_record;

  // Packed BCD orders the same as binary, so a plain unsigned compare suffices.
  assign beats_record = (score_reg > hiscore_reg);

  // game_over sees the pre-update score; its verdict on new_record wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore_reg    <= '0;
      new_record_reg <= 1'b0;
    end else if (game_over) begin
      if (beats_record) begin
        hiscore_reg    <= score_reg;
        new_record_reg <= 1'b1;
      end else begin
        new_record_reg <= 1'b0;
      end
    end else if (clear) begin
      new_record_reg <= 1'b0;
    end
  end

  assign hiscore_bcd = hiscore_reg;
  assign new_record  = new_record_reg;
`else
  logic unused_game_over;

  assign unused_game_over = game_over;
  assign hiscore_bcd      = '0;
  assign new_record       = 1'b0;
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter: a 3-digit saturating unit plus 2-digit saturate/wrap units.
module tb_score_bcd_counter;

  logic clk = 1'b0;
  logic reset;
  logic pt;
  logic clear;
  logic go;

  logic [11:0] s_main, h_main;
  logic        ov_main, nr_main;
  logic [7:0]  s_sat, h_sat, s_wrap, h_wrap;
  logic        ov_sat, nr_sat, ov_wrap, nr_wrap;

  int n_total = 0;
  int n_bad   = 0;
  int ov_main_cnt = 0;
  int ov_sat_cnt  = 0;
  int ov_wrap_cnt = 0;
  int hex_bad_cnt = 0;

  always #5 clk = ~clk;

  score_bcd_counter #(.NUM_DIGITS(3), .SATURATE(1'b1)) u_main (
    .clk(clk), .reset(reset), .point(pt), .clear(clear), .game_over(go),
    .score_bcd(s_main), .overflow(ov_main), .hiscore_bcd(h_main), .new_record(nr_main)
  );

  score_bcd_counter #(.NUM_DIGITS(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .point(pt), .clear(clear), .game_over(go),
    .score_bcd(s_sat), .overflow(ov_sat), .hiscore_bcd(h_sat), .new_record(nr_sat)
  );

  score_bcd_counter #(.NUM_DIGITS(2), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .point(pt), .clear(clear), .game_over(go),
    .score_bcd(s_wrap), .overflow(ov_wrap), .hiscore_bcd(h_wrap), .new_record(nr_wrap)
  );

  function automatic int bad_digits(input logic [31:0] v, input int n);
    int cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (v[4*k +: 4] > 4'd9) cnt++;
    end
    return cnt;
  endfunction

  // Post-edge monitor: counts overflow pulses and any non-decimal digit on every DUT.
  always begin
    @(posedge clk);
    #1;
    if (ov_main) ov_main_cnt++;
    if (ov_sat)  ov_sat_cnt++;
    if (ov_wrap) ov_wrap_cnt++;
    hex_bad_cnt += bad_digits({20'd0, s_main}, 3) + bad_digits({24'd0, s_sat}, 2)
                 + bad_digits({24'd0, s_wrap}, 2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic p);
    pt = p;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse();
    pt = 1'b1;
    tick();
    pt = 1'b0;
    tick();
  endtask

  int snap_main, snap_sat, snap_wrap;

  initial begin
    reset = 1'b1;
    pt    = 1'b0;
    clear = 1'b0;
    go    = 1'b0;
    do_reset(1'b0);

    check("rst_score", {20'd0, s_main}, 32'h000);
    check("rst_overflow", {31'd0, ov_main}, 32'd0);
    check("rst_hiscore", {20'd0, h_main}, 32'h000);
    check("rst_new_record", {31'd0, nr_main}, 32'd0);

    // twelve clean point pulses
    snap_main = ov_main_cnt;
    repeat (12) pulse();
    check("t1_score_12", {20'd0, s_main}, 32'h012);
    check("t1_no_overflow", ov_main_cnt - snap_main, 32'd0);

    // reset in the middle of a game
    reset = 1'b1;
    tick();
    check("midrst_score", {20'd0, s_main}, 32'h000);
    reset = 1'b0;
    tick();

    // point held high through and after reset, then a single long press
    do_reset(1'b1);
    repeat (5) tick();
    check("t2_held_through_reset", {20'd0, s_main}, 32'h000);
    pt = 1'b0;
    tick();
    pt = 1'b1;
    repeat (20) tick();
    check("t2_held_20_counts_once", {20'd0, s_main}, 32'h001);
    pt = 1'b0;
    tick();

    // single-digit carry
    do_reset(1'b0);
    repeat (9) pulse();
    check("t4_score_009", {20'd0, s_main}, 32'h009);
    pulse();
    check("t4_carry_010", {20'd0, s_main}, 32'h010);

    // two-digit max, then one more edge
    do_reset(1'b0);
    repeat (99) pulse();
    check("t3_sat_at_99", {24'd0, s_sat}, 32'h99);
    check("t3_wrap_at_99", {24'd0, s_wrap}, 32'h99);
    check("t4_main_099", {20'd0, s_main}, 32'h099);
    snap_main = ov_main_cnt;
    snap_sat  = ov_sat_cnt;
    snap_wrap = ov_wrap_cnt;
    pt = 1'b1;
    tick();
    check("t3_sat_ovf_high", {31'd0, ov_sat}, 32'd1);
    check("t3_wrap_ovf_high", {31'd0, ov_wrap}, 32'd1);
    check("t3_sat_holds_99", {24'd0, s_sat}, 32'h99);
    check("t3_wrap_to_00", {24'd0, s_wrap}, 32'h00);
    check("t4_carry_100", {20'd0, s_main}, 32'h100);
    check("t4_main_no_ovf", {31'd0, ov_main}, 32'd0);
    pt = 1'b0;
    tick();
    check("t3_sat_ovf_low", {31'd0, ov_sat}, 32'd0);
    check("t3_wrap_ovf_low", {31'd0, ov_wrap}, 32'd0);
    tick();
    check("t3_sat_ovf_one_cycle", ov_sat_cnt - snap_sat, 32'd1);
    check("t3_wrap_ovf_one_cycle", ov_wrap_cnt - snap_wrap, 32'd1);
    check("t3_main_ovf_none", ov_main_cnt - snap_main, 32'd0);
    pulse();
    check("t3_wrap_counts_on", {24'd0, s_wrap}, 32'h01);
    check("t3_sat_still_99", {24'd0, s_sat}, 32'h99);

    // clear wins over a coincident edge; the edge is still consumed
    do_reset(1'b0);
    repeat (5) pulse();
    check("t6_score_005", {20'd0, s_main}, 32'h005);
    clear = 1'b1;
    pt = 1'b1;
    tick();
    check("t6_clear_beats_inc", {20'd0, s_main}, 32'h000);
    check("t6_clear_ovf", {31'd0, ov_main}, 32'd0);
    clear = 1'b0;
    tick();
    check("t6_edge_consumed", {20'd0, s_main}, 32'h000);
    pt = 1'b0;
    tick();
    pulse();
    check("t6_counts_after_clear", {20'd0, s_main}, 32'h001);

`ifdef SCORE_HISCORE_EN
    do_reset(1'b0);
    repeat (42) pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t5_hiscore_042", {20'd0, h_main}, 32'h042);
    check("t5_new_record_set", {31'd0, nr_main}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clear_score", {20'd0, s_main}, 32'h000);
    check("t5_clear_drops_record", {31'd0, nr_main}, 32'd0);
    check("t5_hiscore_survives", {20'd0, h_main}, 32'h042);
    repeat (30) pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t5_hiscore_kept", {20'd0, h_main}, 32'h042);
    check("t5_no_record", {31'd0, nr_main}, 32'd0);
    repeat (20) pulse();
    check("t6_score_050", {20'd0, s_main}, 32'h050);
    go = 1'b1;
    clear = 1'b1;
    pt = 1'b1;
    tick();
    go = 1'b0;
    clear = 1'b0;
    check("t6_go_pre_clear", {20'd0, h_main}, 32'h050);
    check("t6_go_clear_score", {20'd0, s_main}, 32'h000);
    pt = 1'b0;
    tick();
`else
    repeat (7) pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("nohs_hiscore_zero", {20'd0, h_main}, 32'h000);
    check("nohs_record_zero", {31'd0, nr_main}, 32'd0);
`endif

    check("no_hex_digits", hex_bad_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
